// File: rtl/exec_result_arbiter.sv
// exec_result_arbiter: merges results from NUM_UNITS execution units into one registered memory-stage channel.
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   flush_i                     synchronous flush: empties every lane and the output register
//   valid_i / execute*_i        per-unit result (tag, commands, value, flags) offered to its lane FIFO
//   canGo_o                     per-lane "has space" (registered count only, no path from ready_i)
//   valid_o / ready_i           output register valid and memory-stage consume handshake
//   *ToMem_o                    granted result fields
module exec_result_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int DATA_W     = 64,
    parameter int CMD_W      = 10,
    parameter int FLAG_W     = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  flush_i,
    input  logic [NUM_UNITS-1:0]                  valid_i,
    input  logic [NUM_UNITS-1:0][ROBsizeLog-1:0]  executeTag_i,
    input  logic [NUM_UNITS-1:0][CMD_W-1:0]       executeCommands_i,
    input  logic [NUM_UNITS-1:0][DATA_W-1:0]      executeVal_i,
    input  logic [NUM_UNITS-1:0][FLAG_W-1:0]      executeFlags_i,
    output logic [NUM_UNITS-1:0]                  canGo_o,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [DATA_W-1:0]                     dataToMem_o,
    output logic [ROBsizeLog-1:0]                 tagToMem_o,
    output logic [CMD_W-1:0]                      commandsToMem_o,
    output logic [FLAG_W-1:0]                     flagsToMem_o
);
    localparam int E_W  = ROBsizeLog + CMD_W + DATA_W + FLAG_W;
    localparam int RR_W = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0][1:0][E_W-1:0] mem_q, mem_d;
    logic [NUM_UNITS-1:0][1:0]          cnt_q, cnt_d;
    logic [NUM_UNITS-1:0]               rd_q, rd_d;
    logic [RR_W-1:0]                    rr_q, rr_d;
    logic                               valid_q, valid_d;
    logic [E_W-1:0]                     out_q, out_d;
    logic [NUM_UNITS-1:0]               push, pop;
    logic                               load, found;
    logic [RR_W-1:0]                    win;
    int                                 j;

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++)
            canGo_o[i] = cnt_q[i] != 2'd2;
    end

    // Round-robin search starting at rr; only lanes non-empty at the start of the cycle compete.
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_UNITS) j = j - NUM_UNITS;
            if (!found && cnt_q[j] != 2'd0) begin
                found = 1'b1;
                win   = RR_W'(j);
            end
        end
    end

    always_comb begin
        load    = ~valid_q | ready_i;
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        rr_d    = rr_q;
        valid_d = valid_q;
        out_d   = out_q;
        push    = valid_i & canGo_o;
        pop     = '0;
        if (load) begin
            valid_d = found;
            if (found) begin
                pop[win] = 1'b1;
                out_d    = mem_q[win][rd_q[win]];
                rr_d     = win == RR_W'(NUM_UNITS - 1) ? '0 : win + 1'b1;
            end
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            cnt_d[i] = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            rd_d[i]  = rd_q[i] ^ pop[i];
            // Write slot is head+count; a push only happens with count < 2, so count[0] suffices.
            if (push[i])
                mem_d[i][rd_q[i] ^ cnt_q[i][0]] = {executeTag_i[i], executeCommands_i[i],
                                                   executeVal_i[i], executeFlags_i[i]};
        end
        if (flush_i) begin
            cnt_d   = '0;
            rd_d    = '0;
            rr_d    = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            rr_q    <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign valid_o = valid_q;
    assign {tagToMem_o, commandsToMem_o, dataToMem_o, flagsToMem_o} = out_q;
endmodule
